// File: rtl/spi_master_param.sv
// SPI master behind an Avalon-MM slave port, with TX/RX FIFOs, per-CS mode and CS setup/hold.
// Register reads are zero-wait-state; a full TX FIFO drops writes (TXFO), a full RX FIFO drops words (RXFO).

// spi_fifo: power-of-2 FIFO, registered pointers, head visible combinationally.
// A push into a full FIFO is accepted only alongside a pop in the same cycle; otherwise ovf pulses.
module spi_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_vld,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty,
   output logic         ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   // The extra pointer bit separates full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop_vld && !empty;
   assign do_push  = push_vld && (!full || do_pop);
   assign ovf      = push_vld && !do_push;
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

// spi_master_param: word engine pops TX at word start, pushes RX on SHIFT -> CS_HOLD.
// Frame is CS_SETUP (N+1), SHIFT (2*(WS+1)*(N+1)), CS_HOLD (N+1) cycles; ENABLE=0 aborts to IDLE.
module spi_master_param #(
   parameter int DATA_W   = 32,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16,
   parameter int NUM_CS   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic              chipselect,
   input  logic [1:0]        address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              spi_clk,
   output logic              spi_tx,
   input  logic              spi_rx,
   output logic [NUM_CS-1:0] spi_cs,
   output logic              irq
);
   localparam logic [1:0] A_DATA    = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_CONTROL = 2'd2;
   localparam logic [1:0] A_BRD     = 2'd3;
   localparam logic [4:0] WS_MAX    = 5'(DATA_W - 1);

   typedef struct packed {
      logic       ie_rxne;
      logic       ie_txe;
      logic       loopback;
      logic [7:0] mode;
      logic       enable;
      logic [1:0] cs_select;
      logic [3:0] cs_manual;
      logic [3:0] cs_auto;
      logic [4:0] ws;
   } ctrl_t;

   typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

   ctrl_t              ctrl;
   logic [15:0]        brd;
   logic               txfo;
   logic               rxfo;

   state_t             state;
   state_t             state_nxt;
   logic [15:0]        cnt;
   logic [5:0]         half;
   logic [DATA_W-1:0]  shreg;
   logic [DATA_W-1:0]  rx_sh;
   logic [1:0]         act_cs;
   logic [1:0]         act_mode;
   logic [4:0]         act_ws;
   logic [15:0]        act_brd;

   logic               wr_en;
   logic               rd_en;
   logic               tx_push;
   logic               rx_pop;
   logic               tx_pop;
   logic               rx_push;
   logic [DATA_W-1:0]  tx_head;
   logic [DATA_W-1:0]  rx_head;
   logic               tx_full, tx_empty, tx_ovf;
   logic               rx_full, rx_empty, rx_ovf;
   logic [4:0]         ws_eff;
   logic               div_end;
   logic               last_half;
   logic               lead_edge;
   logic               trail_edge;
   logic               sample;
   logic               shift_out;
   logic               rx_in;
   logic [6:0]         status;
   logic               unused_bits;

   assign wr_en   = chipselect && write;
   assign rd_en   = chipselect && read;
   assign tx_push = wr_en && (address == A_DATA);
   assign rx_pop  = rd_en && (address == A_DATA);
   assign ws_eff  = (ctrl.ws > WS_MAX) ? WS_MAX : ctrl.ws;
   assign unused_bits = &{1'b0, writedata[31:27]};

   spi_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (tx_push),
      .push_dat (writedata[DATA_W-1:0]),
      .pop_vld  (tx_pop),
      .head_dat (tx_head),
      .full     (tx_full),
      .empty    (tx_empty),
      .ovf      (tx_ovf)
   );

   spi_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (rx_push),
      .push_dat (rx_sh),
      .pop_vld  (rx_pop),
      .head_dat (rx_head),
      .full     (rx_full),
      .empty    (rx_empty),
      .ovf      (rx_ovf)
   );

   // Register file and sticky overflow flags; a new overflow beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl <= '0;
         brd  <= '0;
         txfo <= 1'b0;
         rxfo <= 1'b0;
      end else begin
         if (wr_en && (address == A_CONTROL)) ctrl <= ctrl_t'(writedata[26:0]);
         if (wr_en && (address == A_BRD))     brd  <= writedata[15:0];
         if (tx_ovf)                                              txfo <= 1'b1;
         else if (wr_en && (address == A_STATUS) && writedata[3]) txfo <= 1'b0;
         if (rx_ovf)                                              rxfo <= 1'b1;
         else if (wr_en && (address == A_STATUS) && writedata[0]) rxfo <= 1'b0;
      end
   end

   assign status = {state != IDLE, tx_empty, tx_full, txfo, rx_empty, rx_full, rxfo};

   always_comb begin
      readdata = '0;
      if (rd_en) begin
         case (address)
            A_DATA:    if (!rx_empty) readdata[DATA_W-1:0] = rx_head;
            A_STATUS:  readdata[6:0]  = status;
            A_CONTROL: readdata[26:0] = ctrl;
            A_BRD:     readdata[15:0] = brd;
            default:   readdata = '0;
         endcase
      end
   end

   assign div_end   = (cnt == act_brd);
   assign last_half = (half == {act_ws, 1'b1});

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      case (state)
         IDLE:     if (ctrl.enable && !tx_empty) begin
                      state_nxt = CS_SETUP;
                      tx_pop    = 1'b1;
                   end
         CS_SETUP: if (div_end) state_nxt = SHIFT;
         SHIFT:    if (div_end && last_half) begin
                      state_nxt = CS_HOLD;
                      rx_push   = 1'b1;
                   end
         CS_HOLD:  if (div_end) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (!ctrl.enable) begin
         state_nxt = IDLE;
         tx_pop    = 1'b0;
         rx_push   = 1'b0;
      end
   end

   // Leading edges start even half-periods (the first one on CS_SETUP exit), trailing edges odd ones.
   assign lead_edge  = div_end && ((state == CS_SETUP) || ((state == SHIFT) && half[0] && !last_half));
   assign trail_edge = div_end && (state == SHIFT) && !half[0];
   assign sample     = act_mode[0] ? trail_edge : lead_edge;
   assign shift_out  = act_mode[0] ? (lead_edge && (state == SHIFT)) : trail_edge;
   assign rx_in      = ctrl.loopback ? spi_tx : spi_rx;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         half     <= '0;
         shreg    <= '0;
         rx_sh    <= '0;
         act_cs   <= '0;
         act_mode <= '0;
         act_ws   <= '0;
         act_brd  <= '0;
      end else begin
         if ((state_nxt != state) || div_end) cnt <= '0;
         else                                 cnt <= cnt + 1'b1;

         if (state != SHIFT) half <= '0;
         else if (div_end)   half <= half + 1'b1;

         if (tx_pop) begin
            // Left-justify so the word's MSB always leaves from the top bit.
            shreg    <= tx_head << (WS_MAX - ws_eff);
            rx_sh    <= '0;
            act_cs   <= ctrl.cs_select;
            act_mode <= ctrl.mode[{ctrl.cs_select, 1'b0} +: 2];
            act_ws   <= ws_eff;
            act_brd  <= brd;
         end else begin
            if (shift_out) shreg <= {shreg[DATA_W-2:0], 1'b0};
            if (sample)    rx_sh <= {rx_sh[DATA_W-2:0], rx_in};
         end
      end
   end

   assign spi_tx  = ((state == CS_SETUP) || (state == SHIFT)) ? shreg[DATA_W-1] : 1'b0;
   assign spi_clk = act_mode[1] ^ ((state == SHIFT) && !half[0]);
   assign irq     = (ctrl.ie_txe && tx_empty) || (ctrl.ie_rxne && !rx_empty);

   always_comb begin
      spi_cs = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         spi_cs[i] = ~(ctrl.cs_manual[i] |
                       (ctrl.cs_auto[i] & (act_cs == 2'(i)) & (state != IDLE)));
      end
   end
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: reset, mode 0 loopback, mode 3 with divider, overflow,
// abort mid-word, manual chip select and RX-not-empty interrupt.
module tb_spi_master_param;
   logic        clk;
   logic        reset;
   logic        read, write, chipselect;
   logic [1:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        spi_clk, spi_tx, spi_rx;
   logic [3:0]  spi_cs;
   logic        irq;

   int          n_cmp = 0;
   int          n_err = 0;
   logic        slave_en;
   logic [31:0] slave_word;

   spi_master_param #(.DATA_W(32), .TX_DEPTH(4), .RX_DEPTH(16), .NUM_CS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .read       (read),
      .write      (write),
      .chipselect (chipselect),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .spi_clk    (spi_clk),
      .spi_tx     (spi_tx),
      .spi_rx     (spi_rx),
      .spi_cs     (spi_cs),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; writedata = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = a;
      #1 d = readdata;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < budget; k++) begin
         bus_read(2'd1, s);
         if ((s & 32'h60) == 32'h20) break;
      end
      check("wait_idle", s & 32'h60, 32'h20);
   endtask

   // Samples one frame on spi_cs[0]; also plays a mode-3 slave when slave_en is set.
   task automatic watch_word(input logic cpol, output int cs_low, output int pulses,
                             output int act, output logic [31:0] txb);
      logic prev;
      logic started;
      cs_low = 0; pulses = 0; act = 0; txb = '0; prev = cpol; started = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (spi_cs[0] == 1'b0) begin
            cs_low++;
            started = 1'b1;
            if (spi_clk != cpol) begin
               act++;
               if (prev == cpol) begin
                  if (slave_en && pulses < 32) spi_rx = slave_word[31 - pulses];
                  pulses++;
                  txb = {txb[30:0], spi_tx};
               end
            end
            prev = spi_clk;
         end else if (started) begin
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      int          cs_low, pulses, act;
      logic [31:0] txb;
      logic        seen;

      reset = 1'b1; read = 1'b0; write = 1'b0; chipselect = 1'b0;
      address = '0; writedata = '0; spi_rx = 1'b0;
      slave_en = 1'b0; slave_word = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state
      #1;
      check("rst_cs", spi_cs, 32'hF);
      check("rst_sclk", spi_clk, 0);
      check("rst_tx", spi_tx, 0);
      check("rst_irq", irq, 0);
      check("rst_readdata_idle", readdata, 0);
      bus_read(2'd1, rd); check("rst_status", rd, 32'h24);
      bus_read(2'd2, rd); check("rst_control", rd, 0);
      bus_read(2'd3, rd); check("rst_brd", rd, 0);

      // Mode 0 loopback, BRD=0, WS=7
      bus_write(2'd3, 32'd0);
      bus_write(2'd2, 32'h0100_8027);
      bus_write(2'd0, 32'hA5);
      watch_word(1'b0, cs_low, pulses, act, txb);
      check("m0_cs_low", cs_low, 18);
      check("m0_pulses", pulses, 8);
      check("m0_high_cycles", act, 8);
      check("m0_tx_bits", txb, 32'hA5);
      bus_read(2'd0, rd); check("m0_rx", rd, 32'hA5);
      bus_read(2'd1, rd); check("m0_status", rd, 32'h24);

      // Mode 3, BRD=2, WS=31, slave returns 0x12345678
      bus_write(2'd3, 32'd2);
      bus_write(2'd2, 32'h0003_803F);
      slave_word = 32'h1234_5678;
      slave_en = 1'b1;
      bus_write(2'd0, 32'hDEAD_BEEF);
      watch_word(1'b1, cs_low, pulses, act, txb);
      slave_en = 1'b0;
      spi_rx = 1'b0;
      check("m3_cs_low", cs_low, 198);
      check("m3_pulses", pulses, 32);
      check("m3_low_cycles", act, 96);
      check("m3_tx_bits", txb, 32'hDEAD_BEEF);
      check("m3_sclk_idle", spi_clk, 1);
      bus_read(2'd0, rd); check("m3_rx", rd, 32'h1234_5678);

      // TX overflow with ENABLE=0
      bus_write(2'd2, 32'h0);
      for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i));
      bus_read(2'd1, rd); check("ovf_status", rd, 32'h1C);
      bus_write(2'd1, 32'h08);
      bus_read(2'd1, rd); check("ovf_w1c", rd, 32'h14);
      bus_write(2'd3, 32'd0);
      bus_write(2'd2, 32'h0100_8007);
      wait_idle(200);
      for (int i = 1; i <= 4; i++) begin
         bus_read(2'd0, rd); check("ovf_drain", rd, 32'(i));
      end
      bus_read(2'd0, rd); check("ovf_fifth_absent", rd, 0);
      bus_read(2'd1, rd); check("ovf_status_end", rd, 32'h24);

      // Abort mid-SHIFT
      bus_write(2'd3, 32'd3);
      bus_write(2'd2, 32'h0100_8027);
      bus_write(2'd0, 32'h81);
      bus_write(2'd0, 32'h82);
      bus_write(2'd0, 32'h83);
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (spi_clk) begin seen = 1'b1; break; end
      end
      check("abort_reached_shift", seen, 1);
      repeat (2) @(negedge clk);
      bus_write(2'd2, 32'h0100_0027);
      @(negedge clk);
      check("abort_cs", spi_cs, 32'hF);
      check("abort_sclk", spi_clk, 0);
      check("abort_tx", spi_tx, 0);
      bus_read(2'd1, rd); check("abort_status", rd, 32'h04);
      bus_write(2'd3, 32'd0);
      bus_write(2'd2, 32'h0100_8027);
      wait_idle(200);
      bus_read(2'd0, rd); check("abort_rx_first", rd, 32'h82);
      bus_read(2'd0, rd); check("abort_rx_second", rd, 32'h83);
      bus_read(2'd0, rd); check("abort_rx_empty", rd, 0);

      // Manual CS2 and RX-not-empty interrupt
      bus_write(2'd2, 32'h0500_0807);
      @(negedge clk);
      check("man_cs_disabled", spi_cs, 32'hB);
      check("man_irq_before", irq, 0);
      bus_write(2'd2, 32'h0500_8827);
      bus_write(2'd0, 32'h3C);
      wait_idle(100);
      check("man_irq_set", irq, 1);
      check("man_cs_after", spi_cs, 32'hB);
      bus_read(2'd0, rd); check("man_rx", rd, 32'h3C);
      #1;
      check("man_irq_clear", irq, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
